// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_I = 2'd1,
        WAIT_D = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam logic [3:0] BE_FULL = 4'hF;

endpackage

// File: rtl/arb_starve_sel.sv
// Two-requester selector: data has priority unless the instruction side has
// waited through STARVE_MAX consecutive data grants.
module arb_starve_sel #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    input  logic d_req,
    input  logic accept,
    output logic grant_i,
    output logic grant_d
);

    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        grant_i = i_req & (~d_req | (cnt_q == CNT_MAX));
        grant_d = d_req & ~grant_i;
    end

    // The count only measures an uninterrupted wait by the fetch side.
    always_comb begin
        cnt_d = cnt_q;
        if (!i_req || (accept && grant_i)) begin
            cnt_d = '0;
        end else if (accept && grant_d && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and the LSU, one transaction in flight,
// with registered response routing and stale-fetch suppression on jumps.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NBITS      = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req,
    input  logic [NBITS-1:0] i_addr,
    input  logic             i_flush,
    output logic             i_ready,
    output logic             i_valid,
    output logic [NBITS-1:0] i_rdata,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [NBITS-1:0] d_addr,
    input  logic [NBITS-1:0] d_wdata,
    input  logic [3:0]       d_be,
    output logic             d_ready,
    output logic             d_valid,
    output logic [NBITS-1:0] d_rdata,
    output logic             mem_req,
    output logic             mem_we,
    output logic [NBITS-1:0] mem_addr,
    output logic [NBITS-1:0] mem_wdata,
    output logic [3:0]       mem_be,
    input  logic             mem_gnt,
    input  logic             mem_valid,
    input  logic [NBITS-1:0] mem_rdata
);

    state_t           state_q;
    logic             drop_q;
    logic             i_valid_q;
    logic             d_valid_q;
    logic [NBITS-1:0] i_rdata_q;
    logic [NBITS-1:0] d_rdata_q;

    logic   idle;
    logic   sel_i;
    logic   sel_d;
    logic   accept;
    owner_t winner;

    assign idle = (state_q == IDLE) && !rst;

    arb_starve_sel #(
        .STARVE_MAX(STARVE_MAX)
    ) u_sel (
        .clk     (clk),
        .rst     (rst),
        .i_req   (i_req),
        .d_req   (d_req),
        .accept  (accept),
        .grant_i (sel_i),
        .grant_d (sel_d)
    );

    assign winner = sel_i ? OWN_I : OWN_D;

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (idle && (sel_i || sel_d)) begin
            mem_req = 1'b1;
            if (winner == OWN_I) begin
                mem_addr = i_addr;
                mem_be   = BE_FULL;
            end else begin
                mem_we    = d_we;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                mem_be    = d_be;
            end
        end
    end

    assign accept  = mem_req & mem_gnt;
    assign i_ready = accept & (winner == OWN_I);
    assign d_ready = accept & (winner == OWN_D);

    // A jump seen at acceptance or while waiting marks the fetch response stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            drop_q    <= 1'b0;
            i_valid_q <= 1'b0;
            d_valid_q <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            i_valid_q <= 1'b0;
            d_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= (winner == OWN_I) ? WAIT_I : WAIT_D;
                        drop_q  <= (winner == OWN_I) && i_flush;
                    end
                end
                WAIT_I: begin
                    if (mem_valid) begin
                        state_q <= IDLE;
                        drop_q  <= 1'b0;
                        if (!drop_q && !i_flush) begin
                            i_valid_q <= 1'b1;
                            i_rdata_q <= mem_rdata;
                        end
                    end else if (i_flush) begin
                        drop_q <= 1'b1;
                    end
                end
                WAIT_D: begin
                    if (mem_valid) begin
                        state_q   <= IDLE;
                        d_valid_q <= 1'b1;
                        d_rdata_q <= mem_rdata;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign i_valid = i_valid_q;
    assign d_valid = d_valid_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of the arbiter.
module tb_mem_arbiter;

  localparam int NBITS      = 32;
  localparam int STARVE_MAX = 4;

  // Handshake: a requester raises x_req with stable fields and holds them until
  // x_ready is seen high in a cycle; memory takes mem_req when mem_gnt is high.
  logic             clk = 1'b0;
  logic             rst;
  logic             i_req, i_flush;
  logic [NBITS-1:0] i_addr;
  logic             i_ready, i_valid;
  logic [NBITS-1:0] i_rdata;
  logic             d_req, d_we;
  logic [NBITS-1:0] d_addr, d_wdata;
  logic [3:0]       d_be;
  logic             d_ready, d_valid;
  logic [NBITS-1:0] d_rdata;
  logic             mem_req, mem_we;
  logic [NBITS-1:0] mem_addr, mem_wdata;
  logic [3:0]       mem_be;
  logic             mem_gnt, mem_valid;
  logic [NBITS-1:0] mem_rdata;

  mem_arbiter #(.NBITS(NBITS), .STARVE_MAX(STARVE_MAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_flush   (i_flush),
    .i_ready   (i_ready),
    .i_valid   (i_valid),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_be      (d_be),
    .d_ready   (d_ready),
    .d_valid   (d_valid),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_gnt   (mem_gnt),
    .mem_valid (mem_valid),
    .mem_rdata (mem_rdata)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [NBITS-1:0] i_exp_q[$];
  logic [NBITS-1:0] d_exp_q[$];

  bit               m_busy = 1'b0;
  bit               m_own_i = 1'b0;
  bit               m_drop = 1'b0;
  int               m_cnt = 0;
  bit               m_iv = 1'b0;
  bit               m_dv = 1'b0;
  logic [NBITS-1:0] m_ird = '0;
  logic [NBITS-1:0] m_drd = '0;
  bit               last_acc_i = 1'b0;
  bit               last_acc_d = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Mid-cycle: check the request side, then advance the model by one clock.
  task automatic step_a();
    bit ereq, gi, gd, acc;
    #1;
    ereq = !rst && !m_busy && (i_req || d_req);
    gi   = ereq && i_req && (!d_req || (m_cnt == STARVE_MAX));
    gd   = ereq && !gi;
    acc  = ereq && mem_gnt;
    check("mem_req", 32'(mem_req), 32'(ereq));
    check("i_ready", 32'(i_ready), 32'(gi && mem_gnt));
    check("d_ready", 32'(d_ready), 32'(gd && mem_gnt));
    if (gi) begin
      check("mem_addr_i", mem_addr, i_addr);
      check("mem_we_i", 32'(mem_we), 32'(0));
      check("mem_be_i", 32'(mem_be), 32'(4'hF));
    end else if (gd) begin
      check("mem_addr_d", mem_addr, d_addr);
      check("mem_wdata_d", mem_wdata, d_wdata);
      check("mem_we_d", 32'(mem_we), 32'(d_we));
      check("mem_be_d", 32'(mem_be), 32'(d_be));
    end else if (rst) begin
      check("mem_addr_rst", mem_addr, 32'(0));
      check("mem_be_rst", 32'(mem_be), 32'(0));
      check("mem_we_rst", 32'(mem_we), 32'(0));
    end
    last_acc_i = acc && gi;
    last_acc_d = acc && gd;
    m_iv = 1'b0;
    m_dv = 1'b0;
    if (rst) begin
      m_busy = 1'b0;
      m_drop = 1'b0;
      m_cnt  = 0;
      m_ird  = '0;
      m_drd  = '0;
    end else begin
      if (m_busy && mem_valid) begin
        if (m_own_i) begin
          if (!(m_drop || i_flush)) begin
            m_iv  = 1'b1;
            m_ird = mem_rdata;
            i_exp_q.push_back(mem_rdata);
          end
          m_drop = 1'b0;
        end else begin
          m_dv  = 1'b1;
          m_drd = mem_rdata;
          d_exp_q.push_back(mem_rdata);
        end
        m_busy = 1'b0;
      end else if (m_busy && m_own_i && i_flush) begin
        m_drop = 1'b1;
      end
      if (acc) begin
        m_busy  = 1'b1;
        m_own_i = gi;
        if (gi && i_flush) m_drop = 1'b1;
      end
      if (!i_req || last_acc_i) m_cnt = 0;
      else if (last_acc_d && m_cnt < STARVE_MAX) m_cnt++;
    end
  endtask

  // After the edge: check the registered response side.
  task automatic step_b();
    logic [NBITS-1:0] e;
    @(posedge clk);
    #1;
    check("i_valid", 32'(i_valid), 32'(m_iv));
    check("d_valid", 32'(d_valid), 32'(m_dv));
    check("i_rdata", i_rdata, m_ird);
    check("d_rdata", d_rdata, m_drd);
    if (i_valid === 1'b1) begin
      if (i_exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL i_resp_sb: got response %h, expected none", i_rdata);
      end else begin
        e = i_exp_q.pop_front();
        check("i_resp_sb", i_rdata, e);
      end
    end
    if (d_valid === 1'b1) begin
      if (d_exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL d_resp_sb: got response %h, expected none", d_rdata);
      end else begin
        e = d_exp_q.pop_front();
        check("d_resp_sb", d_rdata, e);
      end
    end
  endtask

  task automatic step();
    step_a();
    step_b();
  endtask

  task automatic idle_inputs();
    rst = 1'b0; i_req = 1'b0; i_flush = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
    mem_gnt = 1'b0; mem_valid = 1'b0; mem_rdata = '0;
  endtask

  // ---------------- stimulus and checks ----------------
  initial begin
    logic [6:0] seq;
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    check("rst_i_valid", 32'(i_valid), 32'(0));
    check("rst_d_rdata", d_rdata, 32'(0));
    rst = 1'b0;
    step();

    // Single fetch, response two cycles after acceptance.
    i_req = 1'b1; i_addr = 32'h0000_0100; mem_gnt = 1'b1;
    step_a();
    check("t1_i_ready", 32'(i_ready), 32'(1));
    step_b();
    i_req = 1'b0; mem_gnt = 1'b0;
    step();
    mem_valid = 1'b1; mem_rdata = 32'h00e5d463;
    step();
    check("t1_i_valid", 32'(i_valid), 32'(1));
    check("t1_i_rdata", i_rdata, 32'h00e5d463);
    check("t1_d_valid", 32'(d_valid), 32'(0));
    mem_valid = 1'b0;
    step();
    check("t1_i_valid_pulse", 32'(i_valid), 32'(0));

    // Contention: data store first, then the waiting fetch.
    i_req = 1'b1; i_addr = 32'h0000_0104;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_2000; d_wdata = 32'hcafe_0001; d_be = 4'h3;
    mem_gnt = 1'b1;
    step_a();
    check("t2_d_ready", 32'(d_ready), 32'(1));
    check("t2_i_ready", 32'(i_ready), 32'(0));
    check("t2_mem_we", 32'(mem_we), 32'(1));
    check("t2_mem_be", 32'(mem_be), 32'(4'h3));
    step_b();
    d_req = 1'b0; mem_valid = 1'b1; mem_rdata = 32'h0;
    step_a();
    check("t2_wait_no_req", 32'(mem_req), 32'(0));
    step_b();
    check("t2_d_ack", 32'(d_valid), 32'(1));
    mem_valid = 1'b0;
    step_a();
    check("t2_i_grant", 32'(i_ready), 32'(1));
    check("t2_i_be", 32'(mem_be), 32'(4'hF));
    check("t2_i_addr", mem_addr, 32'h0000_0104);
    step_b();
    i_req = 1'b0; mem_valid = 1'b1; mem_rdata = 32'h0000_0013;
    step();
    mem_valid = 1'b0;
    step();

    // Starvation limit: both requesters held continuously.
    i_req = 1'b1; i_addr = 32'h0000_0400; d_req = 1'b1; d_we = 1'b0; d_be = 4'hF;
    mem_gnt = 1'b1; mem_rdata = 32'h1234_5678;
    seq = '0;
    for (int k = 0; k < 7; k++) begin
      mem_valid = 1'b0;
      step_a();
      seq = {seq[5:0], i_ready};
      step_b();
      mem_valid = 1'b1;
      step();
    end
    check("t3_grant_order", 32'(seq), 32'(7'b0000100));
    idle_inputs();
    step();

    // Flush while the fetch is outstanding, then a normal fetch at the target.
    i_req = 1'b1; i_addr = 32'h0000_0200; mem_gnt = 1'b1;
    step();
    i_req = 1'b0; mem_gnt = 1'b0; i_flush = 1'b1;
    step();
    i_flush = 1'b0; mem_valid = 1'b1; mem_rdata = 32'h00e5ef32;
    step();
    check("t4_dropped", 32'(i_valid), 32'(0));
    check("t4_rdata_held", i_rdata, 32'h1234_5678);
    mem_valid = 1'b0; i_req = 1'b1; i_addr = 32'h0100_1100; mem_gnt = 1'b1;
    step_a();
    check("t4_jpc_addr", mem_addr, 32'h0100_1100);
    step_b();
    i_req = 1'b0; mem_gnt = 1'b0; mem_valid = 1'b1; mem_rdata = 32'h00e5d245;
    step();
    check("t4_i_valid", 32'(i_valid), 32'(1));
    check("t4_i_rdata", i_rdata, 32'h00e5d245);
    mem_valid = 1'b0;
    step();

    // Memory back-pressure.
    i_req = 1'b1; i_addr = 32'h0000_0300; mem_gnt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step_a();
      check("t5_stall_ready", 32'(i_ready), 32'(0));
      check("t5_addr_stable", mem_addr, 32'h0000_0300);
      step_b();
    end
    mem_gnt = 1'b1;
    step_a();
    check("t5_accept", 32'(i_ready), 32'(1));
    step_b();
    i_req = 1'b0; mem_gnt = 1'b0; mem_valid = 1'b1; mem_rdata = 32'h0000_0aaa;
    step();
    mem_valid = 1'b0;
    step();

    // Reset while a data transaction is outstanding.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_3000; d_be = 4'hF; mem_gnt = 1'b1;
    step();
    d_req = 1'b0; mem_gnt = 1'b0; rst = 1'b1;
    step_a();
    check("t6_rst_mem_req", 32'(mem_req), 32'(0));
    step_b();
    check("t6_rst_i_rdata", i_rdata, 32'(0));
    check("t6_rst_d_valid", 32'(d_valid), 32'(0));
    rst = 1'b0; mem_valid = 1'b1; mem_rdata = 32'h0bad_0001;
    step();
    check("t6_stale_d_valid", 32'(d_valid), 32'(0));
    check("t6_stale_d_rdata", d_rdata, 32'(0));
    mem_valid = 1'b0;
    step();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if (!i_req || last_acc_i) begin
        i_req  = ($urandom_range(0, 2) != 0);
        i_addr = $urandom;
      end
      if (!d_req || last_acc_d) begin
        d_req   = ($urandom_range(0, 2) != 0);
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = $urandom;
        d_wdata = $urandom;
        d_be    = 4'($urandom_range(0, 15));
      end
      i_flush   = ($urandom_range(0, 7) == 0);
      mem_gnt   = ($urandom_range(0, 3) != 0);
      mem_valid = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      mem_rdata = $urandom;
      rst       = ($urandom_range(0, 149) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
